// File: rtl/clock_gate_pkg.sv
// Shared types for the idle-driven clock-gating controller: per-domain FSM
// states, the decoded per-domain output bundle and default sizing constants.
package clock_gate_pkg;

   localparam int CG_CNT_W_DEFAULT       = 8;
   localparam int CG_WAKE_CYCLES_DEFAULT = 4;

   typedef enum logic [2:0] {
      CG_RUN       = 3'd0,
      CG_IDLE_WAIT = 3'd1,
      CG_SLEEP_REQ = 3'd2,
      CG_GATED     = 3'd3,
      CG_WAKE      = 3'd4
   } cg_state_e;

   typedef struct packed {
      logic clk_en;
      logic ready;
      logic sleep_req;
   } cg_out_t;

   // Output decode for a state; anything not listed behaves like RUN.
   function automatic cg_out_t cg_decode(cg_state_e state);
      cg_out_t outs;
      outs.clk_en    = 1'b1;
      outs.ready     = 1'b1;
      outs.sleep_req = 1'b0;
      case (state)
         CG_SLEEP_REQ: outs.sleep_req = 1'b1;
         CG_GATED: begin
            outs.clk_en = 1'b0;
            outs.ready  = 1'b0;
         end
         CG_WAKE:      outs.ready = 1'b0;
         default:      ;
      endcase
      return outs;
   endfunction

endpackage

// File: rtl/clock_gate_fsm.sv
// One gated domain: idle qualification, sleep handshake, gating and the
// post-wake settle count. Outputs are registered from the next state.
module clock_gate_fsm
   import clock_gate_pkg::*;
#(
   parameter int CNT_W       = CG_CNT_W_DEFAULT,
   parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cfg_enable_i,
   input  logic [CNT_W-1:0] idle_thresh_i,
   input  logic             idle_i,
   input  logic             wake_i,
   input  logic             sleep_ack_i,
   output logic             clk_en_o,
   output logic             ready_o,
   output logic             sleep_req_o
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

   cg_state_e        state;
   cg_state_e        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] thresh_eff;
   logic             leave_sleep;
   cg_out_t          outs_q;

   // A zero threshold behaves as one so the domain always idles at least a cycle.
   assign thresh_eff  = (idle_thresh_i == '0) ? CNT_ONE : idle_thresh_i;
   assign leave_sleep = wake_i | ~cfg_enable_i;

   always_comb begin
      state_nxt = CG_RUN;
      cnt_nxt   = cnt;
      case (state)
         CG_RUN: begin
            if (cfg_enable_i && idle_i && !wake_i) begin
               state_nxt = CG_IDLE_WAIT;
               cnt_nxt   = CNT_ONE;
            end
         end
         CG_IDLE_WAIT: begin
            if (!idle_i || leave_sleep) begin
               state_nxt = CG_RUN;
            end else if (cnt >= thresh_eff) begin
               state_nxt = CG_SLEEP_REQ;
            end else begin
               state_nxt = CG_IDLE_WAIT;
               if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_ONE;
            end
         end
         CG_SLEEP_REQ: begin
            // Wake or disable wins over an acknowledge in the same cycle.
            if (leave_sleep)      state_nxt = CG_RUN;
            else if (sleep_ack_i) state_nxt = CG_GATED;
            else                  state_nxt = CG_SLEEP_REQ;
         end
         CG_GATED: begin
            if (leave_sleep) begin
               state_nxt = CG_WAKE;
               cnt_nxt   = '0;
            end else begin
               state_nxt = CG_GATED;
            end
         end
         CG_WAKE: begin
            if (cnt == WAKE_LAST) begin
               state_nxt = CG_RUN;
            end else begin
               state_nxt = CG_WAKE;
               cnt_nxt   = cnt + CNT_ONE;
            end
         end
         default: state_nxt = CG_RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= CG_RUN;
         cnt    <= '0;
         outs_q <= cg_decode(CG_RUN);
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         outs_q <= cg_decode(state_nxt);
      end
   end

   assign clk_en_o    = outs_q.clk_en;
   assign ready_o     = outs_q.ready;
   assign sleep_req_o = outs_q.sleep_req;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Idle-driven clock-gating controller: one independent FSM per gated domain,
// with the DFT override forcing every gating-cell enable high.
module clock_gate_ctrl
   import clock_gate_pkg::*;
#(
   parameter int NUM_DOMAINS = 2,
   parameter int CNT_W       = CG_CNT_W_DEFAULT,
   parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEFAULT
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cfg_enable_i,
   input  logic                   test_en_i,
   input  logic [CNT_W-1:0]       idle_thresh_i,
   input  logic [NUM_DOMAINS-1:0] idle_i,
   input  logic [NUM_DOMAINS-1:0] wake_i,
   output logic [NUM_DOMAINS-1:0] sleep_req_o,
   input  logic [NUM_DOMAINS-1:0] sleep_ack_i,
   output logic [NUM_DOMAINS-1:0] clk_en_o,
   output logic [NUM_DOMAINS-1:0] ready_o
);

   logic [NUM_DOMAINS-1:0] fsm_clk_en;

   for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_domain
      clock_gate_fsm #(
         .CNT_W       (CNT_W),
         .WAKE_CYCLES (WAKE_CYCLES)
      ) u_fsm (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .cfg_enable_i  (cfg_enable_i),
         .idle_thresh_i (idle_thresh_i),
         .idle_i        (idle_i[k]),
         .wake_i        (wake_i[k]),
         .sleep_ack_i   (sleep_ack_i[k]),
         .clk_en_o      (fsm_clk_en[k]),
         .ready_o       (ready_o[k]),
         .sleep_req_o   (sleep_req_o[k])
      );
   end

   // Test override is combinational; the FSMs keep running underneath it.
   assign clk_en_o = fsm_clk_en | {NUM_DOMAINS{test_en_i}};

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Bench for clock_gate_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a mode/streak reference model.
module tb_clock_gate_ctrl;

   localparam int ND = 2;
   localparam int CW = 8;
   localparam int WC = 4;

   localparam int M_AWAKE  = 0;
   localparam int M_REQ    = 1;
   localparam int M_GATED  = 2;
   localparam int M_WAKING = 3;

   logic          clk;
   logic          rst;
   logic          cfg_enable;
   logic          test_en;
   logic [CW-1:0] idle_thresh;
   logic [ND-1:0] idle;
   logic [ND-1:0] wake;
   logic [ND-1:0] sleep_ack;
   logic [ND-1:0] sleep_req;
   logic [ND-1:0] clk_en;
   logic [ND-1:0] ready;

   int n_checks = 0;
   int n_errors = 0;

   int mode      [ND];
   int streak    [ND];
   int wake_left [ND];

   clock_gate_ctrl #(
      .NUM_DOMAINS (ND),
      .CNT_W       (CW),
      .WAKE_CYCLES (WC)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cfg_enable_i  (cfg_enable),
      .test_en_i     (test_en),
      .idle_thresh_i (idle_thresh),
      .idle_i        (idle),
      .wake_i        (wake),
      .sleep_req_o   (sleep_req),
      .sleep_ack_i   (sleep_ack),
      .clk_en_o      (clk_en),
      .ready_o       (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a domain is awake while its idle streak builds, requests once the
   // streak has reached the threshold, and after a wake spends WC cycles settling.
   function automatic void model_update();
      int th;
      th = (idle_thresh == 0) ? 1 : int'(idle_thresh);
      for (int k = 0; k < ND; k++) begin
         if (rst) begin
            mode[k]   = M_AWAKE;
            streak[k] = 0;
         end else begin
            case (mode[k])
               M_AWAKE: begin
                  if (cfg_enable && idle[k] && !wake[k]) begin
                     if (streak[k] > 0 && streak[k] >= th) begin
                        mode[k]   = M_REQ;
                        streak[k] = 0;
                     end else begin
                        streak[k] = streak[k] + 1;
                     end
                  end else begin
                     streak[k] = 0;
                  end
               end
               M_REQ: begin
                  if (wake[k] || !cfg_enable) mode[k] = M_AWAKE;
                  else if (sleep_ack[k])      mode[k] = M_GATED;
               end
               M_GATED: begin
                  if (wake[k] || !cfg_enable) begin
                     mode[k]      = M_WAKING;
                     wake_left[k] = WC;
                  end
               end
               default: begin
                  wake_left[k] = wake_left[k] - 1;
                  if (wake_left[k] == 0) begin
                     mode[k]   = M_AWAKE;
                     streak[k] = 0;
                  end
               end
            endcase
         end
      end
   endfunction

   task automatic compare_model();
      logic [ND-1:0] e_en, e_rdy, e_req;
      for (int k = 0; k < ND; k++) begin
         e_en[k]  = (mode[k] != M_GATED) || test_en;
         e_rdy[k] = (mode[k] == M_AWAKE) || (mode[k] == M_REQ);
         e_req[k] = (mode[k] == M_REQ);
      end
      chk("model_clk_en", 32'(clk_en), 32'(e_en));
      chk("model_ready", 32'(ready), 32'(e_rdy));
      chk("model_sleep_req", 32'(sleep_req), 32'(e_req));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_model();
   endtask

   initial begin
      int n;
      for (int k = 0; k < ND; k++) begin
         mode[k] = M_AWAKE; streak[k] = 0; wake_left[k] = 0;
      end
      rst = 1'b1; cfg_enable = 1'b0; test_en = 1'b0; idle_thresh = 8'd5;
      idle = '0; wake = '0; sleep_ack = '0;
      step(); step();
      chk("rst_clk_en", 32'(clk_en), 32'h3);
      chk("rst_ready", 32'(ready), 32'h3);
      chk("rst_sleep_req", 32'(sleep_req), 32'h0);

      // Idle threshold of 5 on domain 0.
      rst = 1'b0; cfg_enable = 1'b1; idle = 2'b01;
      step();
      n = 0;
      while (!sleep_req[0] && n < 20) begin step(); n++; end
      chk("req_latency", 32'(n), 32'd5);
      chk("d1_no_req", 32'(sleep_req[1]), 32'd0);

      sleep_ack = 2'b01; step(); sleep_ack = '0;
      chk("gated_clk_en", 32'(clk_en[0]), 32'd0);
      chk("gated_ready", 32'(ready[0]), 32'd0);
      chk("d1_clk_en", 32'(clk_en[1]), 32'd1);

      // Single-cycle wake pulse, then settle.
      wake = 2'b01; step(); wake = '0;
      chk("wake_clk_en", 32'(clk_en[0]), 32'd1);
      chk("wake_ready", 32'(ready[0]), 32'd0);
      n = 0;
      while (!ready[0] && n < 20) begin step(); n++; end
      chk("wake_latency", 32'(n), 32'd4);

      // Idle broken after 3 cycles: full threshold needed afterwards.
      idle = 2'b00; step();
      idle = 2'b01; repeat (3) step();
      idle = 2'b00; step();
      chk("partial_no_req", 32'(sleep_req[0]), 32'd0);
      idle = 2'b01; step();
      n = 0;
      while (!sleep_req[0] && n < 20) begin step(); n++; end
      chk("req_latency_fresh", 32'(n), 32'd5);
      cfg_enable = 1'b0; idle = 2'b00; step();
      chk("disable_drops_req", 32'(sleep_req[0]), 32'd0);
      cfg_enable = 1'b1;

      // Zero threshold behaves as one.
      idle_thresh = 8'd0; idle = 2'b01; step();
      n = 0;
      while (!sleep_req[0] && n < 20) begin step(); n++; end
      chk("req_latency_th0", 32'(n), 32'd1);

      // Wake and ack together in SLEEP_REQ.
      wake = 2'b01; sleep_ack = 2'b01; step();
      wake = '0; sleep_ack = '0; idle = '0;
      chk("wake_ack_req", 32'(sleep_req[0]), 32'd0);
      chk("wake_ack_clk_en", 32'(clk_en[0]), 32'd1);
      chk("wake_ack_ready", 32'(ready[0]), 32'd1);
      step();
      chk("wake_ack_stay_en", 32'(clk_en[0]), 32'd1);

      // Gate both domains, test override, then global disable.
      idle_thresh = 8'd2; idle = 2'b11; step();
      n = 0;
      while (sleep_req != 2'b11 && n < 20) begin step(); n++; end
      chk("both_req", 32'(sleep_req), 32'h3);
      sleep_ack = 2'b11; step(); sleep_ack = '0;
      chk("both_gated", 32'(clk_en), 32'h0);
      test_en = 1'b1; #1;
      chk("test_en_clk_en", 32'(clk_en), 32'h3);
      chk("test_en_ready", 32'(ready), 32'h0);
      step();
      test_en = 1'b0; #1;
      chk("test_en_release", 32'(clk_en), 32'h0);
      cfg_enable = 1'b0; step();
      chk("disable_wake_en", 32'(clk_en), 32'h3);
      chk("disable_wake_rdy", 32'(ready), 32'h0);
      n = 0;
      while (ready != 2'b11 && n < 20) begin step(); n++; end
      chk("disable_wake_latency", 32'(n), 32'd4);
      cfg_enable = 1'b1;

      // Reset with domain 0 mid-WAKE and domain 1 in SLEEP_REQ.
      idle_thresh = 8'd1; step();
      n = 0;
      while (sleep_req != 2'b11 && n < 20) begin step(); n++; end
      sleep_ack = 2'b01; step(); sleep_ack = '0;
      wake = 2'b01; step(); wake = '0;
      step();
      chk("pre_rst_ready", 32'(ready), 32'h2);
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_rst_clk_en", 32'(clk_en), 32'h3);
      chk("mid_rst_ready", 32'(ready), 32'h3);
      chk("mid_rst_req", 32'(sleep_req), 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 199) == 0);
         cfg_enable  = ($urandom_range(0, 19) != 0);
         test_en     = ($urandom_range(0, 29) == 0);
         idle_thresh = CW'($urandom_range(0, 6));
         for (int k = 0; k < ND; k++) begin
            idle[k]      = ($urandom_range(0, 9) != 0);
            wake[k]      = ($urandom_range(0, 14) == 0);
            sleep_ack[k] = ($urandom_range(0, 3) == 0);
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
Idle-driven clock-gating controller for up to NUM_DOMAINS gated clock domains. Each domain has one clk_en_o bit that drives the en_i of that domain's prim_clock_gating cell. A domain is gated only after it has been idle for a programmable number of cycles and has acknowledged a sleep request. The controller ungates the domain on a wake request and holds ready_o low for a fixed settle time. It sits in the always-on clock domain next to the core/peripheral clock tree.

Parameters:
NUM_DOMAINS, 2, number of independently gated domains (1..8)
CNT_W, 8, width of the idle threshold and hysteresis counter
WAKE_CYCLES, 4, cycles between ungating and ready_o reassertion (1..2^CNT_W-1)

Ports:
clk_i  in  1  always-on clock
rst_i  in  1  synchronous reset, active-high
cfg_enable_i  in  1  global gating enable; 0 forces every domain to stay running or to wake
test_en_i  in  1  DFT override; forces all clk_en_o high
idle_thresh_i  in  CNT_W  consecutive idle cycles required before a sleep request; 0 is treated as 1
idle_i  in  NUM_DOMAINS  per-domain idle indication
wake_i  in  NUM_DOMAINS  per-domain wake request, level
sleep_req_o  out  NUM_DOMAINS  per-domain sleep request, held high until acknowledged
sleep_ack_i  in  NUM_DOMAINS  per-domain acknowledge that the domain is quiescent
clk_en_o  out  NUM_DOMAINS  enable to the clock gating cells
ready_o  out  NUM_DOMAINS  domain clocked and settled

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: every domain FSM in RUN, counter = 0, clk_en_o = all 1, sleep_req_o = 0, ready_o = all 1. Asserting rst_i in any state returns the domain to RUN on the next edge; the domain clock is re-enabled at once.
- Each domain has an independent FSM and counter. There is no interaction between domains.
- RUN: clk_en=1, ready=1, req=0.
  - cfg_enable_i & idle_i[k] & !wake_i[k] → IDLE_WAIT, counter cleared to 1.
- IDLE_WAIT: clk_en=1, ready=1, req=0.
  - !idle_i[k] | wake_i[k] | !cfg_enable_i → RUN.
  - Otherwise, if counter >= max(idle_thresh_i, 1) → SLEEP_REQ. Else counter increments.
  - Net effect: sleep_req_o rises exactly idle_thresh_i cycles after idle_i first rises, with idle_i continuously high.
  - Counter saturates, never wraps. idle_thresh_i is sampled live each cycle.
- SLEEP_REQ: req=1, clk_en=1, ready=1.
  - wake_i[k] | !cfg_enable_i → RUN, req drops. This has priority over a same-cycle sleep_ack_i.
  - Else sleep_ack_i[k] → GATED.
  - idle_i is ignored in this state.
- GATED: clk_en=0, ready=0, req=0.
  - wake_i[k] | !cfg_enable_i → WAKE, counter cleared.
  - sleep_ack_i is ignored.
- WAKE: clk_en=1, ready=0, req=0.
  - Counter increments each cycle. At counter == WAKE_CYCLES-1 → RUN.
  - ready_o therefore rises WAKE_CYCLES cycles after clk_en_o rises.
  - wake_i and idle_i are ignored in this state.
- Latency:
  - All outputs are registered or decoded from the state register only.
  - wake_i → clk_en_o high: 1 cycle.
  - sleep_ack_i → clk_en_o low: 1 cycle.
- test_en_i: clk_en_o = fsm_en | test_en_i, combinational. The FSMs keep running unaffected, and ready_o/sleep_req_o follow the FSM.
- Illegal or unused state encodings decode to RUN.

Decomposition:
- Shared package clock_gate_pkg holds:
  - enum cg_state_e {CG_RUN, CG_IDLE_WAIT, CG_SLEEP_REQ, CG_GATED, CG_WAKE}
  - default constants for CNT_W and WAKE_CYCLES.
- Sub-module clock_gate_fsm: one domain's FSM, counter and output decode. The top instantiates it NUM_DOMAINS times in a generate loop and applies the test_en_i OR.

Test Plan:
- Reset, then idle_i[0]=1 held, idle_thresh_i=5, cfg_enable_i=1 → sleep_req_o[0] rises 5 cycles after idle_i rises. sleep_ack_i[0] pulse → clk_en_o[0]=0 and ready_o[0]=0 next cycle. Domain 1 is unaffected.
- From GATED, 1-cycle wake_i[0] pulse, WAKE_CYCLES=4 → clk_en_o[0]=1 next cycle, ready_o[0]=1 exactly 4 cycles later, state RUN.
- idle_i drops after 3 of 5 threshold cycles → no sleep_req_o; a fresh 5-cycle idle period is then required. With idle_thresh_i=0 → sleep_req_o rises after 1 idle cycle.
- In SLEEP_REQ, wake_i and sleep_ack_i asserted in the same cycle → req drops, clk_en_o stays 1, state RUN, never GATED.
- Both domains GATED, cfg_enable_i→0 → both enter WAKE and reach RUN after WAKE_CYCLES. test_en_i=1 while GATED → clk_en_o=1 immediately while ready_o stays 0.
- rst_i asserted mid-WAKE and mid-SLEEP_REQ → next cycle clk_en_o=1, ready_o=1, sleep_req_o=0 for all domains.
